// File: rtl/proc_mem_pkg.sv
// Shared types and widths for the data-memory responder.
package proc_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
// The err signal exists only when DMEM_ERR_EN is defined.
interface data_mem_responder_if;
    import proc_mem_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
`ifdef DMEM_ERR_EN
    logic              err;
`endif

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
`ifdef DMEM_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
`ifdef DMEM_ERR_EN
        , output err
`endif
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, async clear.
module dmem_array
    import proc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Word write on the clock edge; whole array cleared on reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with programmable wait states and pipeline stall.
// Optional feature macro: DMEM_ERR_EN (out-of-range addresses flag err
// instead of wrapping modulo DEPTH).
module data_mem_responder
    import proc_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus,
    output logic                 Stall
);

    localparam int unsigned      IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT   = CNT_W'(LATENCY);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    req_t              lat_req;
    req_t              acc_req;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] arr_rdata;
    logic              accept;
    logic              access;
    logic              in_range;
    logic              we;

    // Access uses the live bus in IDLE (zero-latency case), else the latched request.
    always_comb begin
        acc_req = lat_req;
        if (state == IDLE) begin
            acc_req.write = bus.req_write;
            acc_req.addr  = bus.req_addr;
            acc_req.wdata = bus.req_wdata;
        end
    end

    assign accept = (state == IDLE) && bus.req_valid;
    assign access = (accept && (LATENCY == 0)) ||
                    ((state == WAIT) && (cnt == CNT_W'(1)));

`ifdef DMEM_ERR_EN
    logic err_q;
    assign in_range = acc_req.addr < WORD_W'(DEPTH);
    assign bus.err  = err_q && (state == RESP);
`else
    logic addr_hi_unused;
    assign in_range       = 1'b1;
    assign addr_hi_unused = ^acc_req.addr[WORD_W-1:IDX_W];
`endif

    assign we = access && acc_req.write && in_range;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .Reset (Reset),
        .we    (we),
        .addr  (acc_req.addr[IDX_W-1:0]),
        .wdata (acc_req.wdata),
        .rdata (arr_rdata)
    );

    // Request FSM, wait counter and response data capture.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_req <= '0;
            rdata_q <= '0;
`ifdef DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_req <= acc_req;
                        cnt     <= LAT;
                        state   <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (access) begin
                rdata_q <= (acc_req.write || !in_range) ? '0 : arr_rdata;
`ifdef DMEM_ERR_EN
                err_q   <= !in_range;
`endif
            end
        end
    end

    // Handshake and stall decode; forced low while reset is held.
    assign bus.req_ready = (state == IDLE) && !Reset;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign Stall         = !Reset && (accept || (state == WAIT));

endmodule
